mdu_iter: RTL and testbench

- Parametrised multi-cycle multiply/divide unit for the EX stage of the MIPS pipeline.
- Produces HI/LO results for the following operations:
  - MULT, MULTU
  - MADD, MADDU
  - MSUB, MSUBU
  - DIV, DIVU
- Uses a start/busy/done handshake so the hazard unit can stall the pipeline while the unit is busy.
- HI/LO register storage stays outside the block; current HI/LO values come in on hi_in/lo_in and results go out on hi_out/lo_out.

---
 rtl/mdu_pkg.sv | 34 +++
 rtl/mdu_iter_div.sv | 61 ++++++
 rtl/mdu_iter.sv | 175 +++++++++++++++++
 tb/tb_mdu_iter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared op codes, FSM states and op-class helpers
// for the iterative multiply/divide unit.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_MADD  = 3'd2;
    localparam logic [2:0] MDU_MADDU = 3'd3;
    localparam logic [2:0] MDU_MSUB  = 3'd4;
    localparam logic [2:0] MDU_MSUBU = 3'd5;
    localparam logic [2:0] MDU_DIV   = 3'd6;
    localparam logic [2:0] MDU_DIVU  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIN
    } state_t;

    function automatic logic is_signed(
        input logic [2:0] op
    );
        return op == MDU_MULT || op == MDU_MADD ||
               op == MDU_MSUB || op == MDU_DIV;
    endfunction

    function automatic logic is_div(
        input logic [2:0] op
    );
        return op == MDU_DIV || op == MDU_DIVU;
    endfunction

endpackage

// File: rtl/mdu_iter_div.sv
// Iterative restoring radix-2 unsigned divider,
// one quotient bit per cycle.
module div_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt;
    logic             run;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    assign shifted   = {rem, quo[WIDTH-1]};
    assign diff      = shifted - {1'b0, dvs};
    // high during the last iteration; results valid next cycle
    assign done      = run && (cnt == CW'(1));
    assign quotient  = quo;
    assign remainder = rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            run <= 1'b0;
            cnt <= '0;
            rem <= '0;
            quo <= '0;
            dvs <= '0;
        end else if (clear) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            run <= 1'b1;
            cnt <= CW'(WIDTH);
            rem <= '0;
            quo <= dividend;
            dvs <= divisor;
        end else if (run) begin
            quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
            rem <= diff[WIDTH] ? shifted[WIDTH-1:0]
                               : diff[WIDTH-1:0];
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle MIPS multiply/divide unit: FSM, sign
// handling, multiplier and flush control.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam logic [2:0] MCNT =
        3'((MUL_LAT >= 3) ? MUL_LAT - 3 : 0);

    state_t           state;
    logic [2:0]       cnt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             go;
    logic             dv_start;
    logic             dv_done;
    logic [WIDTH-1:0] dv_q;
    logic [WIDTH-1:0] dv_r;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [2*WIDTH-1:0] fin_res;

    function automatic logic [2*WIDTH-1:0] mul_calc(
        input logic [2:0]       o,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [WIDTH-1:0] h,
        input logic [WIDTH-1:0] l
    );
        logic [2*WIDTH-1:0] xe;
        logic [2*WIDTH-1:0] ye;
        logic [2*WIDTH-1:0] p;
        xe = is_signed(o) ? {{WIDTH{x[WIDTH-1]}}, x}
                          : {{WIDTH{1'b0}}, x};
        ye = is_signed(o) ? {{WIDTH{y[WIDTH-1]}}, y}
                          : {{WIDTH{1'b0}}, y};
        p  = xe * ye;
        case (o)
            MDU_MADD, MDU_MADDU: return {h, l} + p;
            MDU_MSUB, MDU_MSUBU: return {h, l} - p;
            default:             return p;
        endcase
    endfunction

    assign go       = start && !flush;
    assign dv_start = (state == S_IDLE) && go && is_div(op);
    assign a_abs    = (is_signed(op) && a[WIDTH-1]) ? -a : a;
    assign b_abs    = (is_signed(op) && b[WIDTH-1]) ? -b : b;

    div_radix2 #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush),
        .start    (dv_start),
        .dividend (a_abs),
        .divisor  (b_abs),
        .done     (dv_done),
        .quotient (dv_q),
        .remainder(dv_r)
    );

    // divide-by-zero overrides the magnitude result entirely
    always_comb begin
        q_fix = dv_q;
        r_fix = dv_r;
        if (op_q == MDU_DIV && (a_q[WIDTH-1] ^ b_q[WIDTH-1]))
            q_fix = -dv_q;
        if (op_q == MDU_DIV && a_q[WIDTH-1])
            r_fix = -dv_r;
        if (b_q == '0) begin
            q_fix = '1;
            r_fix = a_q;
        end
        fin_res = is_div(op_q)
                ? {r_fix, q_fix}
                : mul_calc(op_q, a_q, b_q, hi_q, lo_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi_out <= '0;
            lo_out <= '0;
            cnt    <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (go) begin
                        op_q <= op;
                        a_q  <= a;
                        b_q  <= b;
                        hi_q <= hi_in;
                        lo_q <= lo_in;
                        if (is_div(op)) begin
                            state <= S_DIV;
                            busy  <= 1'b1;
                        end else if (MUL_LAT == 1) begin
                            {hi_out, lo_out} <=
                                mul_calc(op, a, b, hi_in, lo_in);
                            done <= 1'b1;
                        end else if (MUL_LAT == 2) begin
                            state <= S_FIN;
                            busy  <= 1'b1;
                        end else begin
                            state <= S_MUL;
                            busy  <= 1'b1;
                            cnt   <= MCNT;
                        end
                    end
                end
                S_MUL: begin
                    if (flush) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == '0) begin
                        state <= S_FIN;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                S_DIV: begin
                    if (flush) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (dv_done) begin
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    if (!flush) begin
                        {hi_out, lo_out} <= fin_res;
                        done <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter.
// Inputs driven and outputs sampled on the falling edge.
module tb_mdu_iter;
    import mdu_pkg::*;

    localparam int W   = 32;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         flush;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi_in;
    logic [W-1:0] lo_in;
    logic         busy;
    logic         done;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;

    int ncomp = 0;
    int nfail = 0;
    int lat;
    int nbusy;
    int ndone;

    always #5 clk = ~clk;

    mdu_iter #(
        .WIDTH  (W),
        .MUL_LAT(LAT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .flush (flush),
        .a     (a),
        .b     (b),
        .hi_in (hi_in),
        .lo_in (lo_in),
        .busy  (busy),
        .done  (done),
        .hi_out(hi_out),
        .lo_out(lo_out)
    );

    task automatic check(
        input string       tag,
        input logic [63:0] obs,
        input logic [63:0] exp
    );
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    // one-cycle start pulse; returns on the negedge after the
    // accepting posedge (cycle 1 of the operation)
    task automatic launch(
        input logic [2:0]   o,
        input logic [W-1:0] x,
        input logic [W-1:0] y,
        input logic [W-1:0] h,
        input logic [W-1:0] l
    );
        @(negedge clk);
        op    = o;
        a     = x;
        b     = y;
        hi_in = h;
        lo_in = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int nb);
        cyc = 1;
        nb  = 0;
        while (!done && cyc < 200) begin
            if (busy) nb++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic count_done(input int n, output int k);
        k = 0;
        repeat (n) begin
            @(negedge clk);
            if (done) k++;
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        hi_in = '0;
        lo_in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi_out, lo_out}, 64'd0);
        rst = 1'b0;

        launch(MDU_MULT, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0);
        wait_done(lat, nbusy);
        check("mult_lat", 64'(lat), 64'd4);
        check("mult_busy", 64'(nbusy), 64'd3);
        check("mult_busy_at_done", 64'(busy), 64'd0);
        check("mult_res", {hi_out, lo_out},
              64'hFFFF_FFFF_FFFF_FFFA);
        @(negedge clk);
        check("mult_done_pulse", 64'(done), 64'd0);

        launch(MDU_MSUBU, 32'd3, 32'd4, 32'd0, 32'd10);
        wait_done(lat, nbusy);
        check("msubu_lat", 64'(lat), 64'd4);
        check("msubu_res", {hi_out, lo_out},
              64'hFFFF_FFFF_FFFF_FFFE);

        launch(MDU_MADD, 32'd3, 32'd4, 32'd0, 32'd10);
        wait_done(lat, nbusy);
        check("madd_res", {hi_out, lo_out}, 64'd22);

        launch(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);
        wait_done(lat, nbusy);
        check("div_lat", 64'(lat), 64'd34);
        check("div_neg7_2", {hi_out, lo_out},
              64'hFFFF_FFFF_FFFF_FFFD);

        launch(MDU_DIVU, 32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 32'd0);
        wait_done(lat, nbusy);
        check("divu_big", {hi_out, lo_out},
              64'h8000_0000_0000_0000);

        launch(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 32'd0);
        wait_done(lat, nbusy);
        check("div_ovf", {hi_out, lo_out},
              64'h0000_0000_8000_0000);

        launch(MDU_DIVU, 32'd5, 32'd0, 32'd0, 32'd0);
        wait_done(lat, nbusy);
        check("divu_zero_lat", 64'(lat), 64'd34);
        check("divu_zero", {hi_out, lo_out},
              64'h0000_0005_FFFF_FFFF);

        launch(MDU_DIV, 32'hFFFF_FFFB, 32'd0, 32'd0, 32'd0);
        wait_done(lat, nbusy);
        check("div_zero", {hi_out, lo_out},
              64'hFFFF_FFFB_FFFF_FFFF);

        launch(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'd0, 32'd0);
        wait_done(lat, nbusy);
        check("multu_res", {hi_out, lo_out},
              64'hFFFF_FFFE_0000_0001);

        launch(MDU_DIV, 32'd100, 32'd7, 32'd0, 32'd0);
        repeat (8) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        check("flush_hold", {hi_out, lo_out},
              64'hFFFF_FFFE_0000_0001);
        launch(MDU_MULT, 32'd6, 32'd7, 32'd0, 32'd0);
        wait_done(lat, nbusy);
        check("post_flush_lat", 64'(lat), 64'd4);
        check("post_flush_res", {hi_out, lo_out}, 64'd42);
        count_done(40, ndone);
        check("flush_no_late_done", 64'(ndone), 64'd0);

        launch(MDU_MULT, 32'd5, 32'hFFFF_FFFD, 32'd0, 32'd0);
        op    = MDU_MULTU;
        a     = 32'd100;
        b     = 32'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        count_done(50, ndone);
        check("busy_start_dones", 64'(ndone), 64'd1);
        check("busy_start_res", {hi_out, lo_out},
              64'hFFFF_FFFF_FFFF_FFF1);
        check("busy_start_idle", 64'(busy), 64'd0);

        @(negedge clk);
        op    = MDU_MULT;
        a     = 32'd2;
        b     = 32'd2;
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("sf_busy", 64'(busy), 64'd0);
        count_done(10, ndone);
        check("sf_dones", 64'(ndone), 64'd0);
        check("sf_hold", {hi_out, lo_out},
              64'hFFFF_FFFF_FFFF_FFF1);

        launch(MDU_MULT, 32'd2, 32'd2, 32'd0, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hilo", {hi_out, lo_out}, 64'd0);
        count_done(10, ndone);
        check("midrst_dones", 64'(ndone), 64'd0);

        launch(MDU_MULTU, 32'd3, 32'd3, 32'd0, 32'd0);
        wait_done(lat, nbusy);
        check("post_rst_lat", 64'(lat), 64'd4);
        check("post_rst_res", {hi_out, lo_out}, 64'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncomp, nfail);
        $finish;
    end

endmodule
